// File: rtl/bcd_edit_counter.sv
// N-digit BCD up/down counter with edit cursor and registered 7-segment output.
// Optional cursor blink enabled by defining BCD_EDIT_CURSOR_BLINK_EN.
module bcd_edit_counter #(
  parameter int unsigned DIGITS     = 4,
  parameter int unsigned BLINK_LOG2 = 22
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         inc,
  input  logic                                         dec,
  input  logic                                         cur_left,
  input  logic                                         cur_right,
  input  logic                                         clear,
  input  logic                                         load,
  input  logic [4*DIGITS-1:0]                          load_bcd,
  output logic [4*DIGITS-1:0]                          bcd,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] cursor,
  output logic                                         wrap,
  output logic [8*DIGITS-1:0]                          chars
);

  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CUR_MAX = CW'(DIGITS - 1);

  logic [4*DIGITS-1:0] r_bcd;
  logic [CW-1:0]       r_cursor;
  logic                r_wrap;
  logic [8*DIGITS-1:0] r_chars;

  logic [4*DIGITS-1:0] w_next_bcd;
  logic [CW-1:0]       w_next_cursor;
  logic                w_next_wrap;
  logic [8*DIGITS-1:0] w_next_chars;
  logic                w_carry;
  logic [3:0]          w_dig;
  logic                w_hidden;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      default: seg = 7'h6F;
    endcase
  endfunction

  // Carry/borrow starts at the cursor digit and ripples upward; leftover carry is the wrap.
  always_comb begin
    w_next_bcd  = r_bcd;
    w_next_wrap = 1'b0;
    w_carry     = 1'b0;
    w_dig       = '0;
    if (clear) begin
      w_next_bcd = '0;
    end else if (load) begin
      for (int unsigned i = 0; i < DIGITS; i++) begin
        w_dig = load_bcd[4*i +: 4];
        w_next_bcd[4*i +: 4] = (w_dig > 4'd9) ? 4'd9 : w_dig;
      end
    end else if (inc ^ dec) begin
      w_carry = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        if (i >= 32'(r_cursor) && w_carry) begin
          w_dig = r_bcd[4*i +: 4];
          if (inc) begin
            if (w_dig == 4'd9) begin
              w_next_bcd[4*i +: 4] = 4'd0;
            end else begin
              w_next_bcd[4*i +: 4] = w_dig + 4'd1;
              w_carry              = 1'b0;
            end
          end else begin
            if (w_dig == 4'd0) begin
              w_next_bcd[4*i +: 4] = 4'd9;
            end else begin
              w_next_bcd[4*i +: 4] = w_dig - 4'd1;
              w_carry              = 1'b0;
            end
          end
        end
      end
      w_next_wrap = w_carry;
    end
  end

  always_comb begin
    w_next_cursor = r_cursor;
    if (clear) begin
      w_next_cursor = '0;
    end else if (cur_left && !cur_right) begin
      w_next_cursor = (r_cursor == CUR_MAX) ? '0 : r_cursor + CW'(1);
    end else if (cur_right && !cur_left) begin
      w_next_cursor = (r_cursor == '0) ? CUR_MAX : r_cursor - CW'(1);
    end
  end

  always_comb begin
    w_next_chars = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (i == 32'(r_cursor)) begin
        w_next_chars[8*i +: 8] = {1'b1, (w_hidden ? 7'h00 : seg(r_bcd[4*i +: 4]))};
      end else begin
        w_next_chars[8*i +: 8] = {1'b0, seg(r_bcd[4*i +: 4])};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd    <= '0;
      r_cursor <= '0;
      r_wrap   <= 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        r_chars[8*i +: 8] <= (i == 0) ? 8'hBF : 8'h3F;
      end
    end else begin
      r_bcd    <= w_next_bcd;
      r_cursor <= w_next_cursor;
      r_wrap   <= w_next_wrap;
      r_chars  <= w_next_chars;
    end
  end

`ifdef BCD_EDIT_CURSOR_BLINK_EN
  logic                  w_any_cmd;
  logic [BLINK_LOG2-1:0] r_blink_cnt;
  logic                  r_hidden;

  assign w_any_cmd = inc | dec | cur_left | cur_right | clear | load;

  // Any user action restarts the blink period in the visible phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= '0;
      r_hidden    <= 1'b0;
    end else if (w_any_cmd) begin
      r_blink_cnt <= '0;
      r_hidden    <= 1'b0;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
      if (r_blink_cnt == '1) r_hidden <= ~r_hidden;
    end
  end

  assign w_hidden = r_hidden;
`else
  assign w_hidden = 1'b0;
  // Blink period only matters when the blink feature is built in.
  if (BLINK_LOG2 == 0) begin : g_blink_unused
  end
`endif

  assign bcd    = r_bcd;
  assign cursor = r_cursor;
  assign wrap   = r_wrap;
  assign chars  = r_chars;

endmodule
